addsub16_seq: RTL and testbench

ADDSUB16_SEQ -- requirements
Module: addsub16_seq

---
 rtl/addsub16_seq_pkg.sv | 33 +++
 rtl/addsub16_seq.sv | 152 +++++++++++++++
 tb/tb_addsub16_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/addsub16_seq_pkg.sv
// Shared constants for the 16-bit add/subtract sequencer: FSM encoding,
// adder select-bit positions and the latched request payload.
package addsub16_seq_pkg;

    localparam int unsigned OP_W   = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CO_W   = 2;

    // adr_sel bit positions: [2] reserved (0), [1] subtract, [0] carry-select
    localparam int unsigned SEL_CY_BIT  = 0;
    localparam int unsigned SEL_SUB_BIT = 1;

    // adr_co bit positions
    localparam int unsigned CO_CY_BIT = 0;
    localparam int unsigned CO_AC_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic            op_sub;
        logic            use_cy;
        logic            cy_in;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } req_t;

endpackage

// File: rtl/addsub16_seq.sv
// 16-bit ADD/SUB (optionally with carry/borrow in) computed as two byte passes
// through an external, arbitrated 8-bit adder.
module addsub16_seq
    import addsub16_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_sub,
    input  logic              use_cy,
    input  logic              cy_in,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    output logic              adr_req,
    input  logic              adr_gnt,
    output logic [BYTE_W-1:0] adr_a,
    output logic [BYTE_W-1:0] adr_b,
    output logic              adr_c,
    output logic [SEL_W-1:0]  adr_sel,
    input  logic [BYTE_W-1:0] adr_s,
    input  logic [CO_W-1:0]   adr_co,
    output logic              busy,
    output logic              done,
    output logic [OP_W-1:0]   result,
    output logic              cy_out,
    output logic              ac_out,
    output logic              zero
);

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [BYTE_W-1:0] res_lo_q, res_lo_d;
    logic [BYTE_W-1:0] res_hi_q, res_hi_d;
    logic              cy_mid_q, cy_mid_d;
    logic              cy_out_q, cy_out_d;
    logic              ac_q, ac_d;
    logic              zero_q, zero_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a missing grant simply holds the current byte pass
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)   state_d = ST_LO;
            ST_LO:   if (adr_gnt) state_d = ST_HI;
            ST_HI:   if (adr_gnt) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: request latch, byte results and flags
    always_comb begin
        req_d    = req_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        cy_mid_d = cy_mid_q;
        cy_out_d = cy_out_q;
        ac_d     = ac_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    req_d.op_sub = op_sub;
                    req_d.use_cy = use_cy;
                    req_d.cy_in  = cy_in;
                    req_d.a      = op_a;
                    req_d.b      = op_b;
                end
            end
            ST_LO: begin
                if (adr_gnt) begin
                    res_lo_d = adr_s;
                    cy_mid_d = adr_co[CO_CY_BIT];
                end
            end
            ST_HI: begin
                if (adr_gnt) begin
                    res_hi_d = adr_s;
                    cy_out_d = adr_co[CO_CY_BIT];
                    ac_d     = adr_co[CO_AC_BIT];
                    zero_d   = ({adr_s, res_lo_q} == OP_W'(0));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            cy_mid_q <= 1'b0;
            cy_out_q <= 1'b0;
            ac_q     <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            req_q    <= req_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            cy_mid_q <= cy_mid_d;
            cy_out_q <= cy_out_d;
            ac_q     <= ac_d;
            zero_q   <= zero_d;
        end
    end

    // Output decode; the adder bus is quiet outside the two byte passes
    always_comb begin
        adr_req = 1'b0;
        adr_a   = '0;
        adr_b   = '0;
        adr_c   = 1'b0;
        adr_sel = '0;
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        case (state_q)
            ST_LO: begin
                adr_req              = 1'b1;
                adr_a                = req_q.a[BYTE_W-1:0];
                adr_b                = req_q.b[BYTE_W-1:0];
                adr_c                = req_q.cy_in;
                adr_sel[SEL_SUB_BIT] = req_q.op_sub;
                adr_sel[SEL_CY_BIT]  = req_q.use_cy;
            end
            ST_HI: begin
                adr_req              = 1'b1;
                adr_a                = req_q.a[OP_W-1:BYTE_W];
                adr_b                = req_q.b[OP_W-1:BYTE_W];
                adr_c                = cy_mid_q;
                adr_sel[SEL_SUB_BIT] = req_q.op_sub;
                adr_sel[SEL_CY_BIT]  = 1'b1;
            end
            default: ;
        endcase
    end

    assign result = {res_hi_q, res_lo_q};
    assign cy_out = cy_out_q;
    assign ac_out = ac_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_addsub16_seq.sv
// Bench for addsub16_seq: models the shared 8-bit adder and checks results
// against 16-bit integer arithmetic.
module tb_addsub16_seq;

    logic        clk, rst, start, op_sub, use_cy, cy_in;
    logic [15:0] op_a, op_b;
    logic        adr_req, adr_gnt, adr_c;
    logic [7:0]  adr_a, adr_b, adr_s;
    logic [2:0]  adr_sel;
    logic [1:0]  adr_co;
    logic        busy, done, cy_out, ac_out, zero;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    addsub16_seq dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .use_cy(use_cy),
        .cy_in(cy_in), .op_a(op_a), .op_b(op_b), .adr_req(adr_req),
        .adr_gnt(adr_gnt), .adr_a(adr_a), .adr_b(adr_b), .adr_c(adr_c),
        .adr_sel(adr_sel), .adr_s(adr_s), .adr_co(adr_co), .busy(busy),
        .done(done), .result(result), .cy_out(cy_out), .ac_out(ac_out),
        .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 8-bit adder: SUB computes A-B-c, CY/AC report borrow
    logic       m_c;
    logic [8:0] m_sum;
    logic [4:0] m_nib;
    always_comb begin
        m_c = adr_sel[0] ? adr_c : 1'b0;
        if (adr_sel[1]) begin
            m_sum = {1'b0, adr_a} - {1'b0, adr_b} - 9'(m_c);
            m_nib = {1'b0, adr_a[3:0]} - {1'b0, adr_b[3:0]} - 5'(m_c);
        end else begin
            m_sum = {1'b0, adr_a} + {1'b0, adr_b} + 9'(m_c);
            m_nib = {1'b0, adr_a[3:0]} + {1'b0, adr_b[3:0]} + 5'(m_c);
        end
        adr_s  = m_sum[7:0];
        adr_co = {m_nib[4], m_sum[8]};
    end

    // Reference: {ac, cy, result} from whole-word integer arithmetic
    function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic sub, input logic uc, input logic ci);
        int c, d, n;
        c = (uc && ci) ? 1 : 0;
        if (sub) begin
            d = int'(a) - int'(b) - c;
            n = int'(a & 16'h0FFF) - int'(b & 16'h0FFF) - c;
            return {n < 0, d < 0, 16'(d)};
        end else begin
            d = int'(a) + int'(b) + c;
            n = int'(a & 16'h0FFF) + int'(b & 16'h0FFF) + c;
            return {n > 'hFFF, d > 'hFFFF, 16'(d)};
        end
    endfunction

    // Present a request for one clock edge; returns #1 after that edge (in LO)
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic uc, input logic ci);
        op_a = a; op_b = b; op_sub = sub; use_cy = uc; cy_in = ci;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; adr_gnt = 1'b1;
        op_a = '0; op_b = '0; op_sub = 1'b0; use_cy = 1'b0; cy_in = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        checks++;
        if ({busy, done, adr_req} !== 3'b000)
            begin errors++; $display("FAIL reset_ctrl busy/done/req=%b required 000", {busy, done, adr_req}); end
        checks++;
        if ({result, cy_out, ac_out, zero} !== 19'h0)
            begin errors++; $display("FAIL reset_result got %h/%b%b%b required 0000/000", result, cy_out, ac_out, zero); end
        checks++;
        if ({adr_a, adr_b, adr_c, adr_sel} !== 20'h0)
            begin errors++; $display("FAIL reset_adr got %h %h %b %b required zeros", adr_a, adr_b, adr_c, adr_sel); end
    endtask

    task automatic test_directed();
        int cyc;
        adr_gnt = 1'b1;
        // 0x12FF + 0x0001
        issue(16'h12FF, 16'h0001, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({adr_req, adr_a, adr_b, adr_c, adr_sel} !== {1'b1, 8'hFF, 8'h01, 1'b0, 3'b000})
            begin errors++; $display("FAIL lo_drive got req=%b a=%h b=%h c=%b sel=%b required 1 ff 01 0 000", adr_req, adr_a, adr_b, adr_c, adr_sel); end
        cyc = 1;
        while (done !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (cyc != 3) begin errors++; $display("FAIL add_latency got %0d required 3", cyc); end
        checks++;
        if ({result, cy_out, zero} !== {16'h1300, 1'b0, 1'b0})
            begin errors++; $display("FAIL add_12ff got %h cy=%b z=%b required 1300 0 0", result, cy_out, zero); end
        @(posedge clk); #1;
        checks++;
        if ({done, busy} !== 2'b00) begin errors++; $display("FAIL done_width got done=%b busy=%b required 0 0", done, busy); end

        // 0xFFFF + 0x0001 wraps to zero with carry
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        cyc = 1;
        while (done !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        checks++;
        if ({result, cy_out, zero} !== {16'h0000, 1'b1, 1'b1})
            begin errors++; $display("FAIL add_wrap got %h cy=%b z=%b required 0000 1 1", result, cy_out, zero); end
        @(posedge clk); #1;

        // SBB: 0x1000 - 0x0001 - 1
        issue(16'h1000, 16'h0001, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({adr_c, adr_sel} !== 4'b1011)
            begin errors++; $display("FAIL sbb_lo_sel got c=%b sel=%b required 1 011", adr_c, adr_sel); end
        cyc = 1;
        while (done !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        checks++;
        if ({result, cy_out, zero} !== {16'h0FFE, 1'b0, 1'b0})
            begin errors++; $display("FAIL sbb got %h cy=%b z=%b required 0ffe 0 0", result, cy_out, zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int cyc;
        int bad;
        adr_gnt = 1'b1;
        issue(16'h12FF, 16'h0001, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        cyc = 2;
        adr_gnt = 1'b0;
        bad = 0;
        repeat (4) begin
            if ({adr_req, busy, done, adr_a, adr_b, adr_c, adr_sel} !== {3'b110, 8'h12, 8'h00, 1'b1, 3'b001})
                bad++;
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hi_stall_hold got %0d bad cycles required 0", bad); end
        checks++;
        if ({adr_req, adr_a, adr_c} !== {1'b1, 8'h12, 1'b1})
            begin errors++; $display("FAIL hi_stall_end got req=%b a=%h c=%b required 1 12 1", adr_req, adr_a, adr_c); end
        adr_gnt = 1'b1;
        while (done !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (cyc != 7) begin errors++; $display("FAIL stall_latency got %0d required 7", cyc); end
        checks++;
        if ({result, cy_out} !== {16'h1300, 1'b0})
            begin errors++; $display("FAIL stall_result got %h cy=%b required 1300 0", result, cy_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int seen;
        adr_gnt = 1'b1;
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        checks++;
        if ({busy, done, result, cy_out, zero} !== 19'h0)
            begin errors++; $display("FAIL rst_abort got busy=%b done=%b res=%h cy=%b z=%b required 0 0 0000 0 0", busy, done, result, cy_out, zero); end
        seen = 0;
        repeat (5) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_no_done got %0d active cycles required 0", seen); end
    endtask

    task automatic test_start_busy();
        int act;
        adr_gnt = 1'b1;
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
        op_a = 16'h0F0F; op_b = 16'h0101; op_sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({done, result} !== {1'b1, 16'h5555})
            begin errors++; $display("FAIL busy_start_result got done=%b res=%h required 1 5555", done, result); end
        act = 0;
        repeat (4) begin @(posedge clk); #1; if (busy === 1'b1 || done === 1'b1) act++; end
        checks++;
        if (act != 0 || result !== 16'h5555)
            begin errors++; $display("FAIL busy_start_ignored got %0d active cycles res=%h required 0 5555", act, result); end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic        sub, uc, ci;
        logic [17:0] exp;
        int          cyc;
        for (int n = 0; n < 60; n++) begin
            a = 16'($urandom); b = 16'($urandom);
            if (n % 8 == 0) b = a;
            sub = 1'($urandom); uc = 1'($urandom); ci = 1'($urandom);
            exp = ref_op(a, b, sub, uc, ci);
            issue(a, b, sub, uc, ci);
            cyc = 1;
            while (done !== 1'b1 && cyc < 200) begin
                adr_gnt = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1; cyc++;
            end
            adr_gnt = 1'b1;
            checks++;
            if (done !== 1'b1) begin
                errors++; $display("FAIL rand_timeout op %0d after %0d cycles", n, cyc);
                rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
            end else begin
                checks++;
                if ({ac_out, cy_out, result} !== exp)
                    begin errors++; $display("FAIL rand_op %0d a=%h b=%h sub=%b uc=%b ci=%b got ac=%b cy=%b res=%h required ac=%b cy=%b res=%h",
                                             n, a, b, sub, uc, ci, ac_out, cy_out, result, exp[17], exp[16], exp[15:0]); end
                checks++;
                if (zero !== (exp[15:0] == 16'h0))
                    begin errors++; $display("FAIL rand_zero %0d got %b required %b", n, zero, exp[15:0] == 16'h0); end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_abort();
        test_start_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
